// File: rtl/main_control_sequencer.sv
// EDSAC main-control sequencer: alternates fetch and execute
// minor cycles, with operator start/stop/step and a watchdog.
module main_control_sequencer #(
  parameter int MAX_EXEC_MINOR = 40,
  parameter int CNT_W          = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d35,
  input  logic             start,
  input  logic             stop_req,
  input  logic             single_step,
  input  logic             exec_done,
  input  logic             jump_taken,
  input  logic             stop_order,
  output logic             stage1,
  output logic             stage2,
  output logic             running,
  output logic             scr_inc,
  output logic             bell,
  output logic             timeout_err,
  output logic [CNT_W-1:0] exec_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    FETCH,
    EXEC
  } state_e;

  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_EXEC_MINOR);

  state_e state_q, state_d;

  logic done_q, done_d;
  logic jump_q, jump_d;
  logic zstop_q, zstop_d;
  logic sreq_q, sreq_d;
  logic scr_q, scr_d;
  logic bell_q, bell_d;
  logic tmo_q, tmo_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic run_q, run_d;
  logic [CNT_W-1:0] ec_q, ec_d;

  logic done_now, jump_now, zstop_now, sreq_now;
  logic [CNT_W-1:0] ec_inc;
  logic [CNT_W:0] ec_wide;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    jump_d  = jump_q;
    zstop_d = zstop_q;
    sreq_d  = sreq_q;
    bell_d  = bell_q;
    tmo_d   = tmo_q;
    ec_d    = ec_q;
    scr_d   = 1'b0;

    // a done arriving on the d35 cycle itself still ends the order
    done_now  = done_q | exec_done;
    jump_now  = done_q ? jump_q : jump_taken;
    zstop_now = done_q ? zstop_q : stop_order;
    sreq_now  = sreq_q | stop_req;
    ec_inc    = (ec_q == '1) ? ec_q : ec_q + 1'b1;
    ec_wide   = {1'b0, ec_q} + {{CNT_W{1'b0}}, 1'b1};

    if (state_q != IDLE && stop_req)
      sreq_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          bell_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      ARM: begin
        if (d35)
          state_d = FETCH;
      end
      FETCH: begin
        if (d35) begin
          state_d = EXEC;
          ec_d    = '0;
        end
      end
      EXEC: begin
        if (exec_done && !done_q) begin
          done_d  = 1'b1;
          jump_d  = jump_taken;
          zstop_d = stop_order;
        end
        if (d35) begin
          ec_d = ec_inc;
          if (done_now) begin
            scr_d   = !jump_now;
            done_d  = 1'b0;
            jump_d  = 1'b0;
            zstop_d = 1'b0;
            if (zstop_now) begin
              state_d = IDLE;
              bell_d  = 1'b1;
            end else if (sreq_now || single_step) begin
              state_d = IDLE;
            end else begin
              state_d = FETCH;
            end
          end else if (ec_wide == MAX_W) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end
        end
      end
    endcase

    if (state_d == IDLE)
      sreq_d = 1'b0;

    s1_d  = (state_d == FETCH);
    s2_d  = (state_d == EXEC);
    run_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      jump_q  <= 1'b0;
      zstop_q <= 1'b0;
      sreq_q  <= 1'b0;
      scr_q   <= 1'b0;
      bell_q  <= 1'b0;
      tmo_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      run_q   <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      jump_q  <= jump_d;
      zstop_q <= zstop_d;
      sreq_q  <= sreq_d;
      scr_q   <= scr_d;
      bell_q  <= bell_d;
      tmo_q   <= tmo_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      run_q   <= run_d;
      ec_q    <= ec_d;
    end
  end

  assign stage1      = s1_q;
  assign stage2      = s2_q;
  assign running     = run_q;
  assign scr_inc     = scr_q;
  assign bell        = bell_q;
  assign timeout_err = tmo_q;
  assign exec_cycles = ec_q;

endmodule

// File: doc/main_control_sequencer.md
# main_control_sequencer

Main-control stage sequencer for the EDSAC control section. Alternates the machine between order fetch (stage 1) and order execution (stage 2), one whole minor cycle of 36 digit pulses at a time, with state changes only at minor-cycle boundaries. It handles start, stop and single-step requests from the operator panel, the stop (Z) order, and a watchdog on execution length. Sits beside the coincidence/gating units and drives their stage enables plus the sequence-control-register increment.

## Interface

- MAX_EXEC_MINOR, 40, maximum minor cycles one order may spend in stage 2 before a timeout halt (≥1)
- CNT_W, 6, width of exec_cycles; must hold MAX_EXEC_MINOR

- clk  in  1  system clock; one digit pulse per cycle
- rst_n  in  1  asynchronous, active-low reset
- d35  in  1  digit pulse 35 from digit_pulse_generator; last cycle of a minor cycle
- start  in  1  clear/start request; 1-cycle pulse or level
- stop_req  in  1  halt at the next order boundary
- single_step  in  1  level; halt after every completed order
- exec_done  in  1  arithmetic/transfer unit finished the current order; any cycle
- jump_taken  in  1  current order transferred control; sampled with exec_done
- stop_order  in  1  current order is Z; sampled with exec_done
- stage1  out  1  fetch minor cycle active
- stage2  out  1  execute minor cycle(s) active
- running  out  1  state is ARM, FETCH or EXEC
- scr_inc  out  1  1-cycle pulse: increment sequence control register
- bell  out  1  sticky; halted on a Z order
- timeout_err  out  1  sticky; watchdog halt
- exec_cycles  out  CNT_W  completed stage-2 minor cycles of the current/last order

## Operation

- States: IDLE, ARM, FETCH, EXEC. stage1 = (FETCH), stage2 = (EXEC), running = !IDLE, all registered.
- IDLE: start → ARM; the same edge clears bell and timeout_err. start in any other state is ignored.
- ARM: on d35 → FETCH. A start coincident with d35 still goes to ARM and waits one full minor cycle.
- FETCH: exactly one minor cycle; on d35 → EXEC; exec_cycles ← 0. exec_done/jump_taken/stop_order ignored in FETCH.
- EXEC: exec_done is latched (done_l) together with jump_taken and stop_order on the same edge; the first exec_done per order wins, later ones are ignored. exec_done on the d35 cycle itself counts for that minor cycle.
- EXEC at each d35: exec_cycles increments (saturating at 2^CNT_W−1).
  - Done seen: order ends. scr_inc pulses unless jump latched. Next state: stop latched → IDLE and bell ← 1; else stop_req latched or single_step high → IDLE; else FETCH. Clear done_l.
  - Not done and exec_cycles+1 == MAX_EXEC_MINOR: → IDLE, timeout_err ← 1, no scr_inc.
  - Otherwise stay in EXEC.
- stop_req: latched while running; cleared on entry to IDLE. It takes effect only at order end and never aborts FETCH or EXEC.
- scr_inc fires on a Z order, so a restart resumes at the next order.
- exec_cycles holds its value in IDLE until the next FETCH→EXEC transition.

## Timing

- Reset (async, any state): state IDLE; stage1, stage2, running, scr_inc, bell, timeout_err = 0; exec_cycles = 0; all latches cleared.
- All transitions occur on the clock edge ending the d35 cycle, so new stage outputs are valid from the d0 cycle onward, i.e. exactly 36 cycles per stage minor cycle.
- start → ARM: 1 cycle. ARM → stage1 high: the cycle after the next d35.
- scr_inc is high for exactly the one cycle following the ending d35 (the next d0).
- Minimum order: 72 cycles (36 FETCH + 36 EXEC).
- bell and timeout_err are set in the same cycle that running falls.

## Test plan

- Reset, start, exec_done pulsed at digit 10 of each first EXEC minor cycle → stage1 36 cycles, stage2 36 cycles, scr_inc one cycle at the next d0, repeated; exec_cycles = 1.
- exec_done with jump_taken=1 → order ends after 1 minor cycle, no scr_inc pulse, next FETCH follows directly.
- exec_done on the third EXEC d35 cycle → stage2 for 108 cycles, exec_cycles = 3, scr_inc pulse.
- stop_order with exec_done → scr_inc pulse, IDLE, bell=1, running=0. A later start clears bell and the sequence resumes via ARM.
- MAX_EXEC_MINOR=3, exec_done never → IDLE after 3 stage-2 minor cycles, timeout_err=1, exec_cycles=3, no scr_inc.
- single_step=1 (and separately stop_req pulsed mid-FETCH) → the current order completes, then IDLE. Asserting rst_n=0 mid-EXEC → all outputs 0 immediately, without waiting for a clock edge.
